// File: rtl/clk_ratio_monitor.sv
// Self-check for a clock divider: measures high/low/period of the divided clock in reference
// cycles, compares each period against the programmed ratio and tracks lock and timeout.
module clk_ratio_monitor #(
    parameter int unsigned RATIO_W  = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic               I_ref_clk,
    input  logic               I_rst,
    input  logic               I_en,
    input  logic               I_div_clk,
    input  logic [RATIO_W-1:0] I_exp_ratio,
    output logic [RATIO_W-1:0] o_meas_high,
    output logic [RATIO_W-1:0] o_meas_low,
    output logic [RATIO_W:0]   o_meas_ratio,
    output logic               o_valid,
    output logic               o_mismatch,
    output logic               o_locked,
    output logic               o_timeout
);

    localparam int unsigned         MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam logic [RATIO_W-1:0]  CNT_MAX  = '1;
    localparam logic [MATCH_W-1:0]  LOCK_TGT = MATCH_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC      = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               div_q;
    logic [RATIO_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [RATIO_W-1:0] lo_cnt_q, lo_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [RATIO_W-1:0] meas_high_q, meas_high_d;
    logic [RATIO_W-1:0] meas_low_q, meas_low_d;
    logic [RATIO_W:0]   meas_ratio_q, meas_ratio_d;
    logic               valid_q, valid_d;
    logic               mismatch_q, mismatch_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic               rise_c, fall_c;
    logic [RATIO_W:0]   sum_c;
    logic [RATIO_W-1:0] diff_c;
    logic               check_en_c, period_ok_c;
    logic [MATCH_W-1:0] match_inc_c;
    logic               timeout_hit_c;

    assign rise_c = I_div_clk & ~div_q;
    assign fall_c = ~I_div_clk & div_q;

    // Period check: total must equal the ratio, and the duty split must be as even as possible.
    assign sum_c       = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
    assign diff_c      = (hi_cnt_q >= lo_cnt_q) ? (hi_cnt_q - lo_cnt_q) : (lo_cnt_q - hi_cnt_q);
    assign check_en_c  = (I_exp_ratio >= RATIO_W'(2));
    assign period_ok_c = (sum_c == {1'b0, I_exp_ratio}) &&
                         (I_exp_ratio[0] ? (diff_c == RATIO_W'(1)) : (hi_cnt_q == lo_cnt_q));
    assign match_inc_c = (match_cnt_q == LOCK_TGT) ? match_cnt_q : (match_cnt_q + MATCH_W'(1));

    always_comb begin
        state_d       = state_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        match_cnt_d   = match_cnt_q;
        meas_high_d   = meas_high_q;
        meas_low_d    = meas_low_q;
        meas_ratio_d  = meas_ratio_q;
        valid_d       = 1'b0;
        mismatch_d    = mismatch_q;
        locked_d      = locked_q;
        timeout_d     = timeout_q;
        timeout_hit_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (I_en) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (rise_c) begin
                    hi_cnt_d = RATIO_W'(1);
                    state_d  = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall_c) begin
                    lo_cnt_d = RATIO_W'(1);
                    state_d  = MEAS_LOW;
                end else if (hi_cnt_q == CNT_MAX) begin
                    timeout_hit_c = 1'b1;
                end else begin
                    hi_cnt_d = hi_cnt_q + RATIO_W'(1);
                end
            end
            MEAS_LOW: begin
                if (rise_c) begin
                    meas_high_d  = hi_cnt_q;
                    meas_low_d   = lo_cnt_q;
                    meas_ratio_d = sum_c;
                    valid_d      = 1'b1;
                    timeout_d    = 1'b0;
                    if (!check_en_c) begin
                        mismatch_d  = 1'b0;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                    end else if (period_ok_c) begin
                        mismatch_d  = 1'b0;
                        match_cnt_d = match_inc_c;
                        locked_d    = (match_inc_c == LOCK_TGT);
                    end else begin
                        mismatch_d  = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                    end
                    hi_cnt_d = RATIO_W'(1);
                    lo_cnt_d = '0;
                    state_d  = MEAS_HIGH;
                end else if (lo_cnt_q == CNT_MAX) begin
                    timeout_hit_c = 1'b1;
                end else begin
                    lo_cnt_d = lo_cnt_q + RATIO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit_c) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            hi_cnt_d    = '0;
            lo_cnt_d    = '0;
            state_d     = SYNC;
        end

        // Disable overrides everything except the timeout flag, which still records the event.
        if (!I_en) begin
            state_d      = IDLE;
            hi_cnt_d     = '0;
            lo_cnt_d     = '0;
            match_cnt_d  = '0;
            locked_d     = 1'b0;
            valid_d      = 1'b0;
            meas_high_d  = meas_high_q;
            meas_low_d   = meas_low_q;
            meas_ratio_d = meas_ratio_q;
            mismatch_d   = mismatch_q;
            timeout_d    = timeout_q | timeout_hit_c;
        end
    end

    always_ff @(posedge I_ref_clk) begin
        if (I_rst) begin
            state_q      <= IDLE;
            div_q        <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            match_cnt_q  <= '0;
            meas_high_q  <= '0;
            meas_low_q   <= '0;
            meas_ratio_q <= '0;
            valid_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= I_div_clk;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            match_cnt_q  <= match_cnt_d;
            meas_high_q  <= meas_high_d;
            meas_low_q   <= meas_low_d;
            meas_ratio_q <= meas_ratio_d;
            valid_q      <= valid_d;
            mismatch_q   <= mismatch_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_meas_high  = meas_high_q;
    assign o_meas_low   = meas_low_q;
    assign o_meas_ratio = meas_ratio_q;
    assign o_valid      = valid_q;
    assign o_mismatch   = mismatch_q;
    assign o_locked     = locked_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor: drives I_div_clk cycle by cycle and checks hand-computed results.
module tb_clk_ratio_monitor;

    logic       I_ref_clk;
    logic       I_rst;
    logic       I_en;
    logic       I_div_clk;
    logic [7:0] I_exp_ratio;
    logic [7:0] o_meas_high;
    logic [7:0] o_meas_low;
    logic [8:0] o_meas_ratio;
    logic       o_valid;
    logic       o_mismatch;
    logic       o_locked;
    logic       o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    clk_ratio_monitor #(.RATIO_W(8), .LOCK_CNT(4)) dut (
        .I_ref_clk   (I_ref_clk),
        .I_rst       (I_rst),
        .I_en        (I_en),
        .I_div_clk   (I_div_clk),
        .I_exp_ratio (I_exp_ratio),
        .o_meas_high (o_meas_high),
        .o_meas_low  (o_meas_low),
        .o_meas_ratio(o_meas_ratio),
        .o_valid     (o_valid),
        .o_mismatch  (o_mismatch),
        .o_locked    (o_locked),
        .o_timeout   (o_timeout)
    );

    initial I_ref_clk = 1'b0;
    always #5 I_ref_clk = ~I_ref_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // One reference cycle with the given divided-clock level; outputs are read 1ns after the edge.
    task automatic step(input logic d);
        I_div_clk = d;
        @(posedge I_ref_clk);
        #1;
    endtask

    // Disable for one cycle (clears lock state), then enable; leaves the FSM in SYNC with div low.
    task automatic restart();
        I_en = 1'b0;
        step(1'b0);
        I_en = 1'b1;
        step(1'b0);
    endtask

    task automatic test_reset();
        I_rst = 1'b1; I_en = 1'b0; I_exp_ratio = 8'd0;
        step(1'b0);
        step(1'b0);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_checks++; if (o_meas_ratio !== 9'd0) begin n_fail++; $display("FAIL reset_ratio got %0d exp 0", o_meas_ratio); end
        n_checks++; if (o_meas_high !== 8'd0 || o_meas_low !== 8'd0) begin n_fail++; $display("FAIL reset_hilo got %0d/%0d exp 0/0", o_meas_high, o_meas_low); end
        n_checks++; if ({o_mismatch, o_locked, o_timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {o_mismatch, o_locked, o_timeout}); end
        I_rst = 1'b0;
    endtask

    task automatic test_ratio4();
        int nv = 0;
        logic exp_v;
        I_exp_ratio = 8'd4;
        restart();
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 4; c++) begin
                step(c < 2);
                exp_v = (c == 0 && p > 0);
                n_checks++; if (o_valid !== exp_v) begin n_fail++; $display("FAIL ratio4_valid p=%0d c=%0d got %b exp %b", p, c, o_valid, exp_v); end
                if (o_valid === 1'b1) begin
                    nv++;
                    n_checks++; if (o_meas_high !== 8'd2 || o_meas_low !== 8'd2 || o_meas_ratio !== 9'd4) begin n_fail++; $display("FAIL ratio4_meas got %0d/%0d/%0d exp 2/2/4", o_meas_high, o_meas_low, o_meas_ratio); end
                    n_checks++; if (o_mismatch !== 1'b0) begin n_fail++; $display("FAIL ratio4_mismatch got %b exp 0", o_mismatch); end
                    n_checks++; if (o_locked !== (nv >= 4)) begin n_fail++; $display("FAIL ratio4_locked valid#%0d got %b exp %b", nv, o_locked, nv >= 4); end
                end
            end
        end
        n_checks++; if (nv != 5) begin n_fail++; $display("FAIL ratio4_count got %0d exp 5", nv); end
    endtask

    task automatic test_ratio5();
        int nv = 0;
        int hi;
        logic [7:0] eh;
        I_exp_ratio = 8'd5;
        restart();
        for (int p = 0; p < 6; p++) begin
            hi = (p % 2 == 0) ? 2 : 3;
            for (int c = 0; c < 5; c++) begin
                step(c < hi);
                if (o_valid === 1'b1) begin
                    nv++;
                    eh = ((nv - 1) % 2 == 0) ? 8'd2 : 8'd3;
                    n_checks++; if (o_meas_high !== eh || o_meas_low !== 8'(5 - eh) || o_meas_ratio !== 9'd5) begin n_fail++; $display("FAIL ratio5_meas valid#%0d got %0d/%0d/%0d exp %0d/%0d/5", nv, o_meas_high, o_meas_low, o_meas_ratio, eh, 5 - eh); end
                    n_checks++; if (o_mismatch !== 1'b0) begin n_fail++; $display("FAIL ratio5_mismatch got %b exp 0", o_mismatch); end
                    n_checks++; if (o_locked !== (nv >= 4)) begin n_fail++; $display("FAIL ratio5_locked valid#%0d got %b exp %b", nv, o_locked, nv >= 4); end
                end
            end
        end
        n_checks++; if (nv != 5) begin n_fail++; $display("FAIL ratio5_count got %0d exp 5", nv); end
    endtask

    task automatic test_mismatch6();
        int nv = 0;
        I_exp_ratio = 8'd6;
        restart();
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 4; c++) begin
                step(c < 2);
                if (o_valid === 1'b1) begin
                    nv++;
                    n_checks++; if (o_meas_ratio !== 9'd4) begin n_fail++; $display("FAIL mis6_ratio got %0d exp 4", o_meas_ratio); end
                    n_checks++; if (o_mismatch !== 1'b1 || o_locked !== 1'b0) begin n_fail++; $display("FAIL mis6_flags got mis=%b lock=%b exp mis=1 lock=0", o_mismatch, o_locked); end
                end
            end
        end
        n_checks++; if (nv != 5) begin n_fail++; $display("FAIL mis6_count got %0d exp 5", nv); end
    endtask

    task automatic test_odd_skew();
        int nv = 0;
        I_exp_ratio = 8'd5;
        restart();
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 5; c++) begin
                step(c < 4);
                if (o_valid === 1'b1) begin
                    nv++;
                    n_checks++; if (o_meas_high !== 8'd4 || o_meas_low !== 8'd1 || o_meas_ratio !== 9'd5) begin n_fail++; $display("FAIL skew_meas got %0d/%0d/%0d exp 4/1/5", o_meas_high, o_meas_low, o_meas_ratio); end
                    n_checks++; if (o_mismatch !== 1'b1 || o_locked !== 1'b0) begin n_fail++; $display("FAIL skew_flags got mis=%b lock=%b exp mis=1 lock=0", o_mismatch, o_locked); end
                end
            end
        end
        n_checks++; if (nv != 4) begin n_fail++; $display("FAIL skew_count got %0d exp 4", nv); end
    endtask

    task automatic test_bypass();
        int nv = 0;
        I_exp_ratio = 8'd1;
        restart();
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 3; c++) begin
                step(c < 2);
                if (o_valid === 1'b1) begin
                    nv++;
                    n_checks++; if (o_meas_high !== 8'd2 || o_meas_low !== 8'd1 || o_meas_ratio !== 9'd3) begin n_fail++; $display("FAIL bypass_meas got %0d/%0d/%0d exp 2/1/3", o_meas_high, o_meas_low, o_meas_ratio); end
                    n_checks++; if (o_mismatch !== 1'b0 || o_locked !== 1'b0) begin n_fail++; $display("FAIL bypass_flags got mis=%b lock=%b exp 0/0", o_mismatch, o_locked); end
                end
            end
        end
        n_checks++; if (nv != 5) begin n_fail++; $display("FAIL bypass_count got %0d exp 5", nv); end
    endtask

    task automatic test_timeout();
        int nv = 0;
        int stray = 0;
        I_exp_ratio = 8'd4;
        restart();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++) step(c < 2);
        step(1'b1);
        n_checks++; if (o_valid !== 1'b1 || o_locked !== 1'b1) begin n_fail++; $display("FAIL to_prelock got v=%b lock=%b exp 1/1", o_valid, o_locked); end
        for (int j = 1; j <= 254; j++) begin
            step(1'b1);
            if (o_valid === 1'b1 || o_timeout === 1'b1) stray++;
        end
        n_checks++; if (stray != 0 || o_locked !== 1'b1) begin n_fail++; $display("FAIL to_early got stray=%0d lock=%b exp 0/1", stray, o_locked); end
        step(1'b1);
        n_checks++; if (o_timeout !== 1'b1 || o_locked !== 1'b0) begin n_fail++; $display("FAIL to_hit got to=%b lock=%b exp 1/0", o_timeout, o_locked); end
        for (int j = 0; j < 3; j++) step(1'b1);
        n_checks++; if (o_timeout !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL to_sticky got to=%b v=%b exp 1/0", o_timeout, o_valid); end
        step(1'b0);
        step(1'b0);
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 4; c++) begin
                step(c < 2);
                if (p == 0 && c == 3) begin
                    n_checks++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL to_hold_presync got %b exp 1", o_timeout); end
                end
                if (o_valid === 1'b1) begin
                    nv++;
                    n_checks++; if (o_timeout !== 1'b0 || o_meas_ratio !== 9'd4) begin n_fail++; $display("FAIL to_recover valid#%0d got to=%b ratio=%0d exp 0/4", nv, o_timeout, o_meas_ratio); end
                    n_checks++; if (o_locked !== (nv >= 4)) begin n_fail++; $display("FAIL to_relock valid#%0d got %b exp %b", nv, o_locked, nv >= 4); end
                end
            end
        end
        n_checks++; if (nv != 5) begin n_fail++; $display("FAIL to_count got %0d exp 5", nv); end
    endtask

    task automatic test_enable();
        logic seq [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_v;
        I_exp_ratio = 8'd4;
        restart();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++) step(c < 2);
        step(1'b1);
        n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL en_prelock got %b exp 1", o_locked); end
        step(1'b1);
        step(1'b1);
        step(1'b0);
        I_en = 1'b0;
        step(1'b0);
        n_checks++; if (o_valid !== 1'b0 || o_locked !== 1'b0) begin n_fail++; $display("FAIL en_off got v=%b lock=%b exp 0/0", o_valid, o_locked); end
        step(1'b1);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL en_off_rise got v=%b exp 0", o_valid); end
        n_checks++; if (o_meas_high !== 8'd2 || o_meas_low !== 8'd2 || o_meas_ratio !== 9'd4) begin n_fail++; $display("FAIL en_hold got %0d/%0d/%0d exp 2/2/4", o_meas_high, o_meas_low, o_meas_ratio); end
        I_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(seq[i]);
            exp_v = (i == 7);
            n_checks++; if (o_valid !== exp_v) begin n_fail++; $display("FAIL en_resync_valid step=%0d got %b exp %b", i, o_valid, exp_v); end
        end
        n_checks++; if (o_meas_ratio !== 9'd4 || o_locked !== 1'b0) begin n_fail++; $display("FAIL en_resync got ratio=%0d lock=%b exp 4/0", o_meas_ratio, o_locked); end
    endtask

    task automatic test_reset_mid();
        logic seq [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_v;
        I_exp_ratio = 8'd4;
        restart();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++) step(c < 2);
        step(1'b1);
        step(1'b1);
        n_checks++; if (o_locked !== 1'b1 || o_meas_ratio !== 9'd4) begin n_fail++; $display("FAIL rstmid_pre got lock=%b ratio=%0d exp 1/4", o_locked, o_meas_ratio); end
        I_rst = 1'b1;
        step(1'b0);
        I_rst = 1'b0;
        n_checks++; if ({o_valid, o_mismatch, o_locked, o_timeout} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags got %b exp 0000", {o_valid, o_mismatch, o_locked, o_timeout}); end
        n_checks++; if (o_meas_high !== 8'd0 || o_meas_low !== 8'd0 || o_meas_ratio !== 9'd0) begin n_fail++; $display("FAIL rstmid_meas got %0d/%0d/%0d exp 0/0/0", o_meas_high, o_meas_low, o_meas_ratio); end
        for (int i = 0; i < 7; i++) begin
            step(seq[i]);
            exp_v = (i == 6);
            n_checks++; if (o_valid !== exp_v) begin n_fail++; $display("FAIL rstmid_valid step=%0d got %b exp %b", i, o_valid, exp_v); end
        end
        n_checks++; if (o_meas_high !== 8'd2 || o_meas_low !== 8'd2 || o_meas_ratio !== 9'd4) begin n_fail++; $display("FAIL rstmid_after got %0d/%0d/%0d exp 2/2/4", o_meas_high, o_meas_low, o_meas_ratio); end
    endtask

    initial begin
        I_rst = 1'b1; I_en = 1'b0; I_div_clk = 1'b0; I_exp_ratio = 8'd0;
        test_reset();
        test_ratio4();
        test_ratio5();
        test_mismatch6();
        test_odd_skew();
        test_bypass();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
